// File: rtl/seg7_scroll_scan.sv
// Multi-digit 7-segment scroller/scanner: scrolls a stored BCD string across time-multiplexed digits.
// Optional macro SCROLL_DIR_EN enables reverse scrolling via dir; without it dir is ignored.
module seg7_scroll_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int SEQ_LEN    = 8,
   parameter int SCROLL_DIV = 12500000,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       pause,
   input  logic                       load,
   input  logic [4*SEQ_LEN-1:0]       seq_in,
   input  logic                       dir,
   output logic [6:0]                 seg,
   output logic [NUM_DIGITS-1:0]      an,
   output logic [$clog2(SEQ_LEN)-1:0] pos,
   output logic                       wrap
);

   localparam int PW  = $clog2(SEQ_LEN);
   localparam int DW  = $clog2(NUM_DIGITS);
   localparam int SCW = $clog2(SCROLL_DIV);
   localparam int SNW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PW-1:0]  POS_MAX    = PW'(SEQ_LEN - 1);
   localparam logic [PW:0]    SUM_LEN    = (PW + 1)'(SEQ_LEN);
   localparam logic [DW-1:0]  DIG_MAX    = DW'(NUM_DIGITS - 1);
   localparam logic [SCW-1:0] SCROLL_MAX = SCW'(SCROLL_DIV - 1);
   localparam logic [SNW-1:0] SCAN_MAX   = SNW'(SCAN_DIV - 1);

   logic [4*SEQ_LEN-1:0]  r_seq;
   logic [PW-1:0]         r_pos;
   logic [DW-1:0]         r_scan_idx;
   logic [SNW-1:0]        r_scan_cnt;
   logic [SCW-1:0]        r_scroll_cnt;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;
   logic                  r_wrap;

   logic                  w_scroll_tick;
   logic [PW:0]           w_sum;
   logic [PW:0]           w_sum_mod;
   logic [PW-1:0]         w_elem;
   logic [3:0]            w_code;
   logic [PW-1:0]         w_step_pos;
   logic                  w_at_wrap;
   logic [NUM_DIGITS-1:0] w_an_sel;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      case (code)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         4'd15:   seg_decode = 7'b1111111;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   assign w_scroll_tick = en && !pause && (r_scroll_cnt == SCROLL_MAX);

   // pos and scan_idx are both below SEQ_LEN, so one conditional subtract gives the modulo.
   assign w_sum     = {1'b0, r_pos} + {{(PW + 1 - DW){1'b0}}, r_scan_idx};
   assign w_sum_mod = (w_sum >= SUM_LEN) ? (w_sum - SUM_LEN) : w_sum;
   assign w_elem    = w_sum_mod[PW-1:0];
   assign w_code    = r_seq[{w_elem, 2'b00} +: 4];
   assign w_an_sel  = ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << r_scan_idx);

`ifdef SCROLL_DIR_EN
   always_comb begin
      w_step_pos = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
      w_at_wrap  = (r_pos == POS_MAX);
      if (dir) begin
         w_step_pos = (r_pos == '0) ? POS_MAX : r_pos - PW'(1);
         w_at_wrap  = (r_pos == '0);
      end
   end
`else
   logic w_unused_dir;
   assign w_unused_dir = dir;

   always_comb begin
      w_step_pos = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
      w_at_wrap  = (r_pos == POS_MAX);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seq        <= '0;
         r_pos        <= '0;
         r_scan_idx   <= '0;
         r_scan_cnt   <= '0;
         r_scroll_cnt <= '0;
         r_seg        <= 7'h7F;
         r_an         <= '1;
         r_wrap       <= 1'b0;
      end else begin
         // A load overrides any scroll step in the same cycle and suppresses wrap.
         if (load) begin
            r_seq <= seq_in;
            r_pos <= '0;
         end else if (w_scroll_tick) begin
            r_pos <= w_step_pos;
         end
         r_wrap <= w_scroll_tick && !load && w_at_wrap;

         if (!en) begin
            r_scan_cnt   <= '0;
            r_scan_idx   <= '0;
            r_scroll_cnt <= '0;
            r_seg        <= 7'h7F;
            r_an         <= '1;
         end else begin
            if (r_scan_cnt == SCAN_MAX) begin
               r_scan_cnt <= '0;
               r_scan_idx <= (r_scan_idx == DIG_MAX) ? '0 : r_scan_idx + DW'(1);
            end else begin
               r_scan_cnt <= r_scan_cnt + SNW'(1);
            end

            if (load || w_scroll_tick) begin
               r_scroll_cnt <= '0;
            end else if (!pause) begin
               r_scroll_cnt <= r_scroll_cnt + SCW'(1);
            end

            r_seg <= seg_decode(w_code);
            r_an  <= w_an_sel;
         end
      end
   end

   assign seg  = r_seg;
   assign an   = r_an;
   assign pos  = r_pos;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_seg7_scroll_scan.sv
// Bench for seg7_scroll_scan: cycle-level reference model plus directed literal checks.
// Honours SCROLL_DIR_EN the same way as the design.
module tb_seg7_scroll_scan;

   localparam int NUM_DIGITS = 4;
   localparam int SEQ_LEN    = 8;
   localparam int SCROLL_DIV = 16;
   localparam int SCAN_DIV   = 2;

   localparam logic [31:0] SEQ_A = 32'h2180_1002;
   localparam logic [31:0] SEQ_H = 32'h2180_A002;
   localparam logic [31:0] SEQ_F = 32'h2180_F002;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        pause = 1'b0;
   logic        load = 1'b0;
   logic        dir = 1'b0;
   logic [31:0] seq_in = '0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [2:0]  pos;
   logic        wrap;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seg7_scroll_scan #(
      .NUM_DIGITS(NUM_DIGITS),
      .SEQ_LEN(SEQ_LEN),
      .SCROLL_DIV(SCROLL_DIV),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .pause(pause),
      .load(load),
      .seq_in(seq_in),
      .dir(dir),
      .seg(seg),
      .an(an),
      .pos(pos),
      .wrap(wrap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   function automatic logic [6:0] glyph(input int code);
      case (code)
         0: glyph = 7'b1000000;
         1: glyph = 7'b1111001;
         2: glyph = 7'b0100100;
         3: glyph = 7'b0110000;
         4: glyph = 7'b0011001;
         5: glyph = 7'b0010010;
         6: glyph = 7'b0000010;
         7: glyph = 7'b1111000;
         8: glyph = 7'b0000000;
         9: glyph = 7'b0010000;
         15: glyph = 7'b1111111;
         default: glyph = 7'b0111111;
      endcase
   endfunction

   // Model: elapsed-cycle counts give the scan slot and scroll phase directly.
   int         m_seq[SEQ_LEN];
   int         m_pos = 0;
   int         m_scan_n = 0;
   int         m_scroll_n = 0;
   logic [6:0] e_seg = 7'h7F;
   logic [3:0] e_an = 4'hF;
   logic       e_wrap = 1'b0;

   task automatic model_step();
      int  slot;
      bit  tick;
      bit  rev;
`ifdef SCROLL_DIR_EN
      rev = dir;
`else
      rev = 1'b0;
`endif
      if (en) begin
         slot  = (m_scan_n / SCAN_DIV) % NUM_DIGITS;
         e_seg = glyph(m_seq[(m_pos + slot) % SEQ_LEN]);
         e_an  = ~(4'b0001 << slot);
      end else begin
         e_seg = 7'h7F;
         e_an  = 4'hF;
      end
      tick   = en && !pause && ((m_scroll_n % SCROLL_DIV) == SCROLL_DIV - 1);
      e_wrap = 1'b0;
      if (load) begin
         for (int i = 0; i < SEQ_LEN; i++) m_seq[i] = int'(seq_in[4*i +: 4]);
         m_pos      = 0;
         m_scroll_n = 0;
      end else if (tick) begin
         e_wrap     = rev ? (m_pos == 0) : (m_pos == SEQ_LEN - 1);
         m_pos      = rev ? (m_pos + SEQ_LEN - 1) % SEQ_LEN : (m_pos + 1) % SEQ_LEN;
         m_scroll_n = m_scroll_n + 1;
      end else if (en && !pause) begin
         m_scroll_n = m_scroll_n + 1;
      end
      if (!en) begin
         m_scan_n   = 0;
         m_scroll_n = 0;
      end else begin
         m_scan_n = m_scan_n + 1;
      end
   endtask

   initial begin
      for (int i = 0; i < SEQ_LEN; i++) m_seq[i] = 0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < SEQ_LEN; i++) m_seq[i] = 0;
            m_pos      = 0;
            m_scan_n   = 0;
            m_scroll_n = 0;
            e_seg      = 7'h7F;
            e_an       = 4'hF;
            e_wrap     = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("model", {17'b0, seg, an, wrap, pos}, {17'b0, e_seg, e_an, e_wrap, 3'(m_pos)});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_an(input logic [3:0] v, input int lim);
      int k = 0;
      while (an !== v && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("wait_an", {28'b0, an}, {28'b0, v});
   endtask

   task automatic wait_pos(input logic [2:0] v, input int lim);
      int k = 0;
      while (pos !== v && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("wait_pos", {29'b0, pos}, {29'b0, v});
   endtask

   initial begin
      int         nw;
      int         k;
      logic [2:0] prev_pos;
      logic [2:0] wrap_pos;
      logic [2:0] wrap_prev;
      logic [2:0] p0;
      logic [3:0] seen;
      int         moved;

      #1 rst = 1'b0;
      cyc(3);
      chk("rst_seg", {25'b0, seg}, 32'h7F);
      chk("rst_an", {28'b0, an}, 32'hF);
      chk("rst_pos", {29'b0, pos}, 32'h0);
      chk("rst_wrap", {31'b0, wrap}, 32'h0);

      rst = 1'b1; en = 1'b1; seq_in = SEQ_A; load = 1'b1;
      cyc(1);
      load = 1'b0;
      cyc(1);
      chk("first_seg", {25'b0, seg}, 32'b0100100);
      chk("an_slot0", {28'b0, an}, 32'b1110);
      cyc(1);
      chk("an_slot1", {28'b0, an}, 32'b1101);
      cyc(2);
      chk("an_slot2", {28'b0, an}, 32'b1011);
      cyc(2);
      chk("an_slot3", {28'b0, an}, 32'b0111);

      cyc(10);
      chk("pos_after16", {29'b0, pos}, 32'd1);
      cyc(1);
      wait_an(4'b1110, 8);
      chk("d0_pos1", {25'b0, seg}, 32'b1000000);
      wait_an(4'b0111, 8);
      chk("d3_pos1", {25'b0, seg}, 32'b1000000);
      wait_an(4'b1011, 8);
      chk("d2_pos1", {25'b0, seg}, 32'b1111001);

      wait_pos(3'd5, SCROLL_DIV * 5);
      cyc(1);
      wait_an(4'b1110, 8);
      chk("d0_pos5", {25'b0, seg}, 32'b0000000);

      nw = 0; wrap_pos = '1; wrap_prev = '0; prev_pos = pos;
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         if (wrap) begin
            nw++;
            wrap_pos  = pos;
            wrap_prev = prev_pos;
         end
         prev_pos = pos;
      end
      chk("wrap_count", nw, 32'd1);
      chk("wrap_pos", {29'b0, wrap_pos}, 32'd0);
      chk("wrap_prev", {29'b0, wrap_prev}, 32'd7);

      p0 = pos; seen = '0; moved = 0;
      pause = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (pos !== p0) moved++;
         seen = seen | ~an;
      end
      chk("pause_hold", moved, 32'd0);
      chk("pause_scan", {28'b0, seen}, 32'hF);
      pause = 1'b0;

      k = 0;
      while (!(m_pos == 7 && (m_scroll_n % SCROLL_DIV) == SCROLL_DIV - 1) && k < 200) begin
         cyc(1);
         k++;
      end
      chk("tick_found", {31'b0, (k < 200)}, 32'd1);
      chk("pre_load_pos", {29'b0, pos}, 32'd7);
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("load_tick_pos", {29'b0, pos}, 32'd0);
      chk("load_tick_wrap", {31'b0, wrap}, 32'd0);

      en = 1'b0;
      cyc(1);
      chk("dis_seg", {25'b0, seg}, 32'h7F);
      chk("dis_an", {28'b0, an}, 32'hF);
      chk("dis_wrap", {31'b0, wrap}, 32'd0);
      cyc(2);
      seq_in = SEQ_H; load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("dis_load_seg", {25'b0, seg}, 32'h7F);
      en = 1'b1;
      cyc(2);
      wait_an(4'b0111, 8);
      chk("dash", {25'b0, seg}, 32'b0111111);

      seq_in = SEQ_F; load = 1'b1;
      cyc(1);
      load = 1'b0;
      cyc(1);
      wait_an(4'b0111, 8);
      chk("blank", {25'b0, seg}, 32'b1111111);

      #3 rst = 1'b0;
      #1;
      chk("arst_seg", {25'b0, seg}, 32'h7F);
      chk("arst_an", {28'b0, an}, 32'hF);
      chk("arst_pos", {29'b0, pos}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cyc(2);
      wait_an(4'b1110, 8);
      chk("arst_cleared", {25'b0, seg}, 32'b1000000);

      seq_in = SEQ_A; load = 1'b1; dir = 1'b1;
      cyc(1);
      load = 1'b0;
      k = 0;
      while (pos == 3'd0 && k < 40) begin
         cyc(1);
         k++;
      end
`ifdef SCROLL_DIR_EN
      chk("dir_pos", {29'b0, pos}, 32'd7);
      chk("dir_wrap", {31'b0, wrap}, 32'd1);
      cyc(1);
      wait_an(4'b1110, 8);
      chk("dir_d0", {25'b0, seg}, 32'b0100100);
`else
      chk("dir_pos", {29'b0, pos}, 32'd1);
      chk("dir_wrap", {31'b0, wrap}, 32'd0);
      cyc(1);
      wait_an(4'b1110, 8);
      chk("dir_d0", {25'b0, seg}, 32'b1000000);
`endif
      dir = 1'b0;
      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
